vga_pll_reset_sequencer: RTL and testbench



---
 rtl/vga_pll_reset_sequencer.sv | 179 +++++++++++++++++
 tb/tb_vga_pll_reset_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pll_reset_sequencer.sv
// vga_pll_reset_sequencer
//
// Supervises the 25 MHz VGA pixel-clock PLL from the 100 MHz reference side.
// The sequencer pulses the PLL reset and waits for lock. It requires lock to
// stay high for a run of consecutive samples, then releases the video-domain
// reset request. On timeout it retries the relock, and after MAX_RETRIES
// timeouts it parks in FAULT. A loss of lock while running restarts the
// whole sequence.
//
// Optional feature macro: VGA_PLL_SEQ_LOSS_CNT_EN
//   defined   -> lock_loss_cnt is a saturating count of lock losses in RUN
//   undefined -> lock_loss_cnt is tied to zero
//
// Ports:
//   refclk        in   sole clock (100 MHz reference)
//   rst           in   synchronous, active-high reset
//   pll_locked    in   raw PLL lock, asynchronous (double-flopped here)
//   restart       in   single-cycle request to re-sequence from any state
//   pll_rst       out  PLL reset, active-high
//   vga_rst_req   out  video-domain reset request, always !ready
//   ready         out  PLL locked and qualified
//   fault         out  relock abandoned
//   retry_count   out  [3:0] timeouts since rst/restart/entry to RUN
//   lock_loss_cnt out  [7:0] saturating count of lock losses in RUN
module vga_pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       vga_rst_req,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_cnt
);

  localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t           state, state_nxt;
  logic             lock_p0, lock_p1;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
  logic [STB_W-1:0] stb_cnt, stb_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             tmo_hit;
  logic             loss_evt;
  logic             pll_rst_nxt, ready_nxt, fault_nxt;

  // lock synchronizer -> state register
  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_p0     <= 1'b0;
      lock_p1     <= 1'b0;
      state       <= S_PLL_RST;
      rst_cnt     <= '0;
      stb_cnt     <= '0;
      tmo_cnt     <= '0;
      retry_count <= 4'd0;
      pll_rst     <= 1'b1;
      vga_rst_req <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      lock_p0     <= pll_locked;
      lock_p1     <= lock_p0;
      state       <= state_nxt;
      rst_cnt     <= rst_cnt_nxt;
      stb_cnt     <= stb_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      retry_count <= retry_nxt;
      pll_rst     <= pll_rst_nxt;
      vga_rst_req <= !ready_nxt;
      ready       <= ready_nxt;
      fault       <= fault_nxt;
    end
  end

  // Next state. The timeout is checked before any lock event, so a timeout
  // wins when lock drops on the same cycle.
  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    stb_cnt_nxt = stb_cnt;
    tmo_cnt_nxt = tmo_cnt;
    retry_nxt   = retry_count;
    loss_evt    = 1'b0;
    tmo_hit     = (tmo_cnt == TMO_W'(LOCK_TIMEOUT_CYCLES - 1));
    if (restart) begin
      state_nxt   = S_PLL_RST;
      rst_cnt_nxt = '0;
      retry_nxt   = 4'd0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (rst_cnt == RST_W'(PLL_RST_CYCLES - 1)) begin
            state_nxt   = S_WAIT_LOCK;
            tmo_cnt_nxt = '0;
          end else begin
            rst_cnt_nxt = rst_cnt + 1'b1;
          end
        end
        S_WAIT_LOCK, S_STABILIZE: begin
          if (tmo_hit) begin
            retry_nxt   = retry_count + 4'd1;
            rst_cnt_nxt = '0;
            state_nxt   = (retry_nxt == 4'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
          end else begin
            tmo_cnt_nxt = tmo_cnt + 1'b1;
            if (state == S_WAIT_LOCK) begin
              if (lock_p1) begin
                state_nxt   = S_STABILIZE;
                stb_cnt_nxt = '0;
              end
            end else if (!lock_p1) begin
              state_nxt   = S_WAIT_LOCK;
              stb_cnt_nxt = '0;
            end else if (stb_cnt == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
              // The sample that entered STABILIZE plus LOCK_STABLE_CYCLES more
              state_nxt = S_RUN;
              retry_nxt = 4'd0;
            end else begin
              stb_cnt_nxt = stb_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!lock_p1) begin
            state_nxt   = S_PLL_RST;
            rst_cnt_nxt = '0;
            loss_evt    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered with it
  always_comb begin
    pll_rst_nxt = (state_nxt == S_PLL_RST) || (state_nxt == S_FAULT);
    ready_nxt   = (state_nxt == S_RUN);
    fault_nxt   = (state_nxt == S_FAULT);
  end

`ifdef VGA_PLL_SEQ_LOSS_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_loss_cnt <= 8'd0;
    end else if (loss_evt) begin
      lock_loss_cnt <= sat_inc8(lock_loss_cnt);
    end
  end
`else
  logic loss_evt_unused;
  assign loss_evt_unused = loss_evt;
  assign lock_loss_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_vga_pll_reset_sequencer.sv
// Testbench for vga_pll_reset_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a timestamp-based reference model.
module tb_vga_pll_reset_sequencer;

  localparam int P    = 4;
  localparam int L    = 8;
  localparam int T    = 64;
  localparam int MAXR = 2;

  localparam int M_PULSE = 0;
  localparam int M_WAIT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  logic       refclk = 1'b0;
  logic       rst, pll_locked, restart;
  logic       pll_rst, vga_rst_req, ready, fault;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  vga_pll_reset_sequencer #(
    .PLL_RST_CYCLES     (P),
    .LOCK_STABLE_CYCLES (L),
    .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES        (MAXR)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .vga_rst_req  (vga_rst_req),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: phases with entry timestamps and a run length of
  // consecutive synchronized-high lock samples.
  int   m_mode = M_PULSE;
  int   m_ent = 0;
  int   m_hi = 0;
  int   m_retries = 0;
  int   m_losses = 0;
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;

  always @(posedge refclk) begin
    logic seen;
    cyc++;
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_locked;
    if (rst) begin
      m_mode = M_PULSE; m_ent = cyc; m_retries = 0; m_losses = 0;
      m_s1 = 1'b0; m_s2 = 1'b0;
    end else if (restart) begin
      m_mode = M_PULSE; m_ent = cyc; m_retries = 0;
    end else begin
      case (m_mode)
        M_PULSE: if (cyc - m_ent == P) begin
          m_mode = M_WAIT; m_ent = cyc; m_hi = 0;
        end
        M_WAIT: begin
          if (cyc - m_ent == T) begin
            m_retries++;
            m_ent  = cyc;
            m_mode = (m_retries == MAXR) ? M_FAULT : M_PULSE;
          end else begin
            m_hi = seen ? m_hi + 1 : 0;
            if (m_hi == L + 1) begin
              m_mode = M_RUN; m_retries = 0;
            end
          end
        end
        M_RUN: if (!seen) begin
          if (m_losses < 255) m_losses++;
          m_mode = M_PULSE; m_ent = cyc;
        end
        default: ;
      endcase
    end
  end

  function automatic int exp_loss();
`ifdef VGA_PLL_SEQ_LOSS_CNT_EN
    return m_losses;
`else
    return 0;
`endif
  endfunction

  always @(negedge refclk) begin
    if (chk_en) begin
      check_val("pll_rst", int'(pll_rst), int'(m_mode == M_PULSE || m_mode == M_FAULT));
      check_val("ready", int'(ready), int'(m_mode == M_RUN));
      check_val("vga_rst_req", int'(vga_rst_req), int'(m_mode != M_RUN));
      check_val("fault", int'(fault), int'(m_mode == M_FAULT));
      check_val("retry_count", int'(retry_count), m_retries);
      check_val("lock_loss_cnt", int'(lock_loss_cnt), exp_loss());
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic wait_ready(input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      if (ready === val) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_val("wait_ready_timeout", 0, 1);
    @(posedge refclk);
    #1;
  endtask

  initial begin
    int at, t0, rise, drop, n_hi, t_lo, t_f, hold;
    bit any_rdy;
    rst = 1'b1; pll_locked = 1'b0; restart = 1'b0;
    @(posedge refclk); #1;
    chk_en = 1'b1;
    tick(2);

    // Reset values
    @(negedge refclk);
    check_val("rst_pll_rst", int'(pll_rst), 1);
    check_val("rst_vga_rst_req", int'(vga_rst_req), 1);
    check_val("rst_ready", int'(ready), 0);
    check_val("rst_fault", int'(fault), 0);
    check_val("rst_retry", int'(retry_count), 0);
    check_val("rst_loss", int'(lock_loss_cnt), 0);
    @(posedge refclk); #1;
    rst = 1'b0;
    t0 = cyc;

    // Clean lock
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge refclk);
      if (pll_rst) n_hi++;
      else break;
    end
    check_val("clean_pulse_len", n_hi, P);
    @(posedge refclk); #1;
    while (cyc < t0 + 10) tick(1);
    pll_locked = 1'b1;
    rise = cyc;
    wait_ready(1'b1, 100, at);
    check_val("clean_ready_latency", at - rise, L + 3);
    check_val("clean_retry", int'(retry_count), 0);

    // Loss in RUN: one-cycle drop
    tick(3);
    pll_locked = 1'b0;
    drop = cyc;
    tick(1);
    pll_locked = 1'b1;
    t_lo = -1; n_hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge refclk);
      if (t_lo < 0 && !ready) t_lo = cyc;
      if (pll_rst) n_hi++;
    end
    check_val("loss_ready_latency", t_lo - drop, 3);
    check_val("loss_pulse_len", n_hi, P);
    check_val("loss_relocked", int'(ready), 1);
`ifdef VGA_PLL_SEQ_LOSS_CNT_EN
    check_val("loss_cnt_one", int'(lock_loss_cnt), 1);
`else
    check_val("loss_cnt_zero", int'(lock_loss_cnt), 0);
`endif
    @(posedge refclk); #1;

    // Glitchy lock
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    any_rdy = 1'b0;
    for (int i = 0; i < 30; i++) begin
      pll_locked = ((i / 5) % 2) == 0;
      @(negedge refclk);
      if (ready) any_rdy = 1'b1;
      @(posedge refclk); #1;
    end
    check_val("glitch_no_ready", int'(any_rdy), 0);
    pll_locked = 1'b1;
    rise = cyc;
    wait_ready(1'b1, 40, at);
    check_val("glitch_ready_latency", at - rise, L + 3);

    // Timeout to fault
    pll_locked = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    t0 = cyc;
    t_f = -1; n_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge refclk);
      if (fault) begin
        t_f = cyc;
        break;
      end
      if (pll_rst) n_hi++;
    end
    check_val("fault_time", t_f - t0, MAXR * (P + T));
    check_val("fault_pulse_cycles", n_hi, MAXR * P);
    @(posedge refclk); #1;
    tick(50);
    @(negedge refclk);
    check_val("fault_held", int'(fault), 1);
    check_val("fault_pll_rst", int'(pll_rst), 1);
    check_val("fault_retry", int'(retry_count), MAXR);
    check_val("fault_ready", int'(ready), 0);
    @(posedge refclk); #1;

    // Restart out of FAULT, then rst in STABILIZE
    restart = 1'b1;
    pll_locked = 1'b1;
    tick(1);
    restart = 1'b0;
    t0 = cyc;
    @(negedge refclk);
    check_val("restart_fault_clr", int'(fault), 0);
    check_val("restart_pll_rst", int'(pll_rst), 1);
    check_val("restart_retry_clr", int'(retry_count), 0);
    @(posedge refclk); #1;
    while (cyc < t0 + 8) tick(1);
    rst = 1'b1;
    tick(1);
    @(negedge refclk);
    check_val("midrst_pll_rst", int'(pll_rst), 1);
    check_val("midrst_vga_rst_req", int'(vga_rst_req), 1);
    check_val("midrst_ready", int'(ready), 0);
    check_val("midrst_fault", int'(fault), 0);
    check_val("midrst_retry", int'(retry_count), 0);
    check_val("midrst_loss", int'(lock_loss_cnt), 0);
    @(posedge refclk); #1;
    rst = 1'b0;

    // Random stimulus
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 40);
      end
      hold--;
      restart = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick(1);
    end
    restart = 1'b0;
    rst = 1'b0;

    // Saturation of the lock-loss counter
    pll_locked = 1'b1;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    wait_ready(1'b1, 200, at);
    for (int k = 0; k < 260; k++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_ready(1'b0, 10, at);
      wait_ready(1'b1, 60, at);
    end
    @(negedge refclk);
`ifdef VGA_PLL_SEQ_LOSS_CNT_EN
    check_val("loss_saturated", int'(lock_loss_cnt), 255);
`else
    check_val("loss_tied_zero", int'(lock_loss_cnt), 0);
`endif
    @(posedge refclk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
